// File: rtl/reaction_pkg.sv
// rtl/reaction_pkg.sv - shared state encoding, LED levels and LFSR constants for the reaction game
package reaction_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RWAIT   = 3'd1,
        EARLY   = 3'd2,
        TIME    = 3'd3,
        DISPLAY = 3'd4,
        LATE    = 3'd5
    } state_t;

    localparam logic [2:0]  LED_OFF   = 3'b000;
    localparam logic [2:0]  LED_ON    = 3'b011;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// rtl/ms_tick_gen.sv - free-running prescaler emitting a one-cycle tick every TICK_DIV clocks
module ms_tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/reaction_game_ctrl.sv
// rtl/reaction_game_ctrl.sv - multi-player reaction timer with random pre-wait, arbitration and best-time tracking
module reaction_game_ctrl #(
    parameter int NPLAYERS    = 2,
    parameter int TIME_W      = 10,
    parameter int TICK_DIV    = 100000,
    parameter int MIN_WAIT_MS = 1000,
    parameter int RAND_W      = 11,
    parameter int TIMEOUT_MS  = 999,
    parameter int HOLD_MS     = 5000,
    localparam int WIN_W      = (NPLAYERS > 1) ? $clog2(NPLAYERS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NPLAYERS-1:0] enter,
    input  logic                clear_best,
    output logic [2:0]          color_r,
    output logic [2:0]          color_g,
    output logic [2:0]          color_b,
    output logic [TIME_W-1:0]   react_time,
    output logic [TIME_W-1:0]   best_time,
    output logic [WIN_W-1:0]    winner,
    output logic [NPLAYERS-1:0] early_mask,
    output logic                result_valid,
    output logic                rs_en
);

    import reaction_pkg::*;

    localparam int WAIT_MAX = MIN_WAIT_MS + (1 << RAND_W) - 1;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam int HOLD_W   = $clog2(HOLD_MS + 1);

    localparam logic [WAIT_W-1:0] MIN_WAIT  = WAIT_W'(MIN_WAIT_MS);
    localparam logic [TIME_W-1:0] TIMEOUT   = TIME_W'(TIMEOUT_MS);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_MS);

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d, wait_load;
    logic [TIME_W-1:0]   time_q, time_d;
    logic [TIME_W-1:0]   react_q, react_d;
    logic [TIME_W-1:0]   best_q, best_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [WIN_W-1:0]    winner_q, winner_d, first_idx;
    logic [NPLAYERS-1:0] early_q, early_d;
    logic [NPLAYERS-1:0] enter_q, press;
    logic                valid_q, valid_d;
    logic                hold_run;
    logic [15:0]         lfsr_q;
    logic                tick;

    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Only rising edges count, so a button held across a state change is ignored.
    assign press     = enter & ~enter_q;
    assign wait_load = MIN_WAIT + WAIT_W'(lfsr_q[RAND_W-1:0]);

    always_comb begin
        first_idx = '0;
        for (int i = NPLAYERS - 1; i >= 0; i--) begin
            if (press[i]) begin
                first_idx = WIN_W'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        time_d   = time_q;
        hold_d   = hold_q;
        react_d  = react_q;
        best_d   = best_q;
        winner_d = winner_q;
        early_d  = early_q;
        valid_d  = 1'b0;
        hold_run = 1'b0;
        color_r  = LED_OFF;
        color_g  = LED_OFF;
        color_b  = LED_OFF;
        rs_en    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RWAIT;
                    wait_d  = wait_load;
                    time_d  = '0;
                end
            end
            RWAIT: begin
                if (|press) begin
                    state_d = EARLY;
                    early_d = press;
                    hold_d  = HOLD_LOAD;
                end else if (tick) begin
                    wait_d = wait_q - WAIT_W'(1);
                    if (wait_q <= WAIT_W'(1)) begin
                        state_d = TIME;
                    end
                end
            end
            TIME: begin
                color_g = LED_ON;
                if (|press) begin
                    state_d  = DISPLAY;
                    winner_d = first_idx;
                    react_d  = time_q;
                    valid_d  = 1'b1;
                    hold_d   = HOLD_LOAD;
                    if (time_q < best_q) begin
                        best_d = time_q;
                    end
                end else if (time_q == TIMEOUT) begin
                    state_d = LATE;
                    hold_d  = HOLD_LOAD;
                end else if (tick) begin
                    time_d = time_q + TIME_W'(1);
                end
            end
            EARLY: begin
                color_r  = LED_ON;
                hold_run = 1'b1;
            end
            LATE: begin
                color_r  = LED_ON;
                color_g  = LED_ON;
                hold_run = 1'b1;
            end
            DISPLAY: begin
                color_g = LED_ON;
                rs_en   = 1'b1;
                if (start) begin
                    state_d = RWAIT;
                    wait_d  = wait_load;
                    time_d  = '0;
                end else begin
                    hold_run = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (hold_run && tick) begin
            if (hold_q <= HOLD_W'(1)) begin
                state_d = IDLE;
                hold_d  = '0;
            end else begin
                hold_d = hold_q - HOLD_W'(1);
            end
        end

        if (clear_best) begin
            best_d = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wait_q   <= '0;
            time_q   <= '0;
            hold_q   <= '0;
            react_q  <= '0;
            best_q   <= '1;
            winner_q <= '0;
            early_q  <= '0;
            valid_q  <= 1'b0;
            enter_q  <= '0;
            lfsr_q   <= LFSR_SEED;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            time_q   <= time_d;
            hold_q   <= hold_d;
            react_q  <= react_d;
            best_q   <= best_d;
            winner_q <= winner_d;
            early_q  <= early_d;
            valid_q  <= valid_d;
            enter_q  <= enter;
            lfsr_q   <= lfsr_next(lfsr_q);
        end
    end

    assign react_time   = react_q;
    assign best_time    = best_q;
    assign winner       = winner_q;
    assign early_mask   = early_q;
    assign result_valid = valid_q;

endmodule
